// File: rtl/ac_sweep_pkg.sv
// Purpose: shared state encoding and default widths for the AC sweep sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ac_sweep_pkg;

    localparam int AC_FW = 24;  // frequency word width
    localparam int AC_NW = 10;  // point count / index width
    localparam int AC_SW = 16;  // settle counter width
    localparam int AC_DW = 32;  // measurement width

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_OUTPUT  = 3'd4,
        S_DONE    = 3'd5
    } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Purpose: loadable down-counter with a zero flag, timing the post-load settle window.
// Latency: count visible the cycle after load; zero is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module sweep_settle_timer
    import ac_sweep_pkg::*;
#(
    parameter int SW = AC_SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [SW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;

    // Load wins over decrement; the count never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - SW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ac_sweep_sequencer.sv
// Purpose: steps an AC source through n_points frequencies, settles, measures, and streams results.
// Latency: per point 1 LOAD + (settle_cycles+1) SETTLE + >=2 MEASURE + >=1 OUTPUT cycles.
// Backpressure: res_valid holds with stable index/data until res_ready; the sweep stalls meanwhile.
module ac_sweep_sequencer
    import ac_sweep_pkg::*;
#(
    parameter int FW = AC_FW,
    parameter int NW = AC_NW,
    parameter int SW = AC_SW,
    parameter int DW = AC_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_step,
    input  logic [NW-1:0] n_points,
    input  logic [SW-1:0] settle_cycles,
    output logic [FW-1:0] freq_out,
    output logic          freq_load,
    output logic          meas_start,
    input  logic          meas_done,
    input  logic [DW-1:0] meas_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [NW-1:0] res_index,
    output logic [DW-1:0] res_data,
    output logic          busy,
    output logic          done
);

    sweep_state_e  state_q, state_d;
    logic [FW-1:0] freq_q, freq_d;
    logic [FW-1:0] step_q, step_d;
    logic [NW-1:0] npts_q, npts_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [NW-1:0] index_q, index_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          meas_first_q, meas_first_d;  // marks the trigger cycle of MEASURE
    logic          zero_done_q, zero_done_d;    // done pulse for an empty sweep
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_zero;
    logic          last_pt;

    sweep_settle_timer #(
        .SW (SW)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (settle_q),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign last_pt = (index_q == (npts_q - NW'(1)));

    // Next-state and datapath updates; abort pre-empts every other event.
    always_comb begin
        state_d      = state_q;
        freq_d       = freq_q;
        step_d       = step_q;
        npts_d       = npts_q;
        settle_d     = settle_q;
        index_d      = index_q;
        res_data_d   = res_data_q;
        meas_first_d = 1'b0;
        zero_done_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (n_points != '0) begin
                            step_d   = f_step;
                            npts_d   = n_points;
                            settle_d = settle_cycles;
                            index_d  = '0;
                            freq_d   = f_start;
                            state_d  = S_LOAD;
                        end else begin
                            zero_done_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    tmr_load = 1'b1;
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (tmr_zero) begin
                        meas_first_d = 1'b1;
                        state_d      = S_MEASURE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                S_MEASURE: begin
                    // A completion seen in the trigger cycle belongs to an earlier request.
                    if (!meas_first_q && meas_done) begin
                        res_data_d = meas_data;
                        state_d    = S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        if (last_pt) begin
                            state_d = S_DONE;
                        end else begin
                            index_d = index_q + NW'(1);
                            freq_d  = freq_q + step_q;
                            state_d = S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            freq_q       <= '0;
            step_q       <= '0;
            npts_q       <= '0;
            settle_q     <= '0;
            index_q      <= '0;
            res_data_q   <= '0;
            meas_first_q <= 1'b0;
            zero_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_q       <= freq_d;
            step_q       <= step_d;
            npts_q       <= npts_d;
            settle_q     <= settle_d;
            index_q      <= index_d;
            res_data_q   <= res_data_d;
            meas_first_q <= meas_first_d;
            zero_done_q  <= zero_done_d;
        end
    end

    assign freq_out   = freq_q;
    assign freq_load  = (state_q == S_LOAD);
    assign meas_start = (state_q == S_MEASURE) && meas_first_q;
    assign res_valid  = (state_q == S_OUTPUT);
    assign res_index  = index_q;
    assign res_data   = res_data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE) || zero_done_q;

endmodule

// File: tb/tb_ac_sweep_sequencer.sv
module tb_ac_sweep_sequencer;

    localparam int FW = 24;
    localparam int NW = 10;
    localparam int SW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, meas_done, res_ready;
    logic [FW-1:0] f_start, f_step;
    logic [NW-1:0] n_points;
    logic [SW-1:0] settle_cycles;
    logic [DW-1:0] meas_data;
    logic [FW-1:0] freq_out;
    logic          freq_load, meas_start, res_valid, busy, done;
    logic [NW-1:0] res_index;
    logic [DW-1:0] res_data;

    // Narrow-frequency instance for the wrap case.
    logic          w_start;
    logic          w_abort    = 1'b0;
    logic          w_mdone    = 1'b1;
    logic          w_rready   = 1'b1;
    logic [7:0]    w_fstart   = 8'd250;
    logic [7:0]    w_fstep    = 8'd10;
    logic [NW-1:0] w_npts     = 10'd2;
    logic [SW-1:0] w_settle   = 16'd0;
    logic [DW-1:0] w_mdata    = 32'h55;
    logic [7:0]    w_freq_out;
    logic          w_freq_load, w_meas_start, w_res_valid, w_busy, w_done;
    logic [NW-1:0] w_res_index;
    logic [DW-1:0] w_res_data;

    always #5 clk = ~clk;

    ac_sweep_sequencer #(.FW(FW), .NW(NW), .SW(SW), .DW(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_points(n_points), .settle_cycles(settle_cycles),
        .freq_out(freq_out), .freq_load(freq_load), .meas_start(meas_start),
        .meas_done(meas_done), .meas_data(meas_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .res_data(res_data), .busy(busy), .done(done)
    );

    ac_sweep_sequencer #(.FW(8), .NW(NW), .SW(SW), .DW(DW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort),
        .f_start(w_fstart), .f_step(w_fstep), .n_points(w_npts), .settle_cycles(w_settle),
        .freq_out(w_freq_out), .freq_load(w_freq_load), .meas_start(w_meas_start),
        .meas_done(w_mdone), .meas_data(w_mdata), .res_valid(w_res_valid), .res_ready(w_rready),
        .res_index(w_res_index), .res_data(w_res_data), .busy(w_busy), .done(w_done)
    );

    typedef struct packed {
        logic [NW-1:0] idx;
        logic [DW-1:0] dat;
    } res_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   exp_freq[$];
    res_t exp_res[$];
    int   exp_done[$];   // expected done cycle, -1 = any cycle
    int   w_exp_freq[$];
    int   exp_gap = 0;
    int   last_load_cyc = 0;
    int   meas_lat = 2;
    bit   hold_chk = 1'b0;
    int   w_idx_exp = 0;
    int   w_ms_cnt = 0;
    int   w_done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event present, required absent (cycle %0d)", name, cyc);
    endtask

    // Monitor: samples 2ns after the falling edge, after drivers have settled.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (freq_load) begin
                    if (hold_chk) flag("freq_load during hold");
                    if (exp_freq.size() == 0) flag("unexpected freq_load");
                    else chk("freq_out", freq_out, exp_freq.pop_front());
                    last_load_cyc = cyc;
                end
                if (meas_start) chk("load->meas_start gap", cyc - last_load_cyc, exp_gap);
                if (res_valid) begin
                    if (exp_res.size() == 0) flag("unexpected res_valid");
                    else begin
                        e = exp_res[0];
                        chk("res_index", res_index, e.idx);
                        chk("res_data", res_data, e.dat);
                        if (res_ready) void'(exp_res.pop_front());
                    end
                end
                if (hold_chk) chk("res_valid held", res_valid, 1);
                if (done) begin
                    if (exp_done.size() == 0) flag("unexpected done");
                    else begin
                        int t;
                        t = exp_done.pop_front();
                        if (t >= 0) chk("done cycle", cyc, t);
                    end
                end
                if (w_freq_load) begin
                    if (w_exp_freq.size() == 0) flag("w unexpected freq_load");
                    else chk("w freq_out", w_freq_out, w_exp_freq.pop_front());
                end
                if (w_res_valid && w_rready) begin
                    chk("w res_index", w_res_index, w_idx_exp);
                    chk("w res_data", w_res_data, 32'h55);
                    w_idx_exp++;
                end
                if (w_meas_start) w_ms_cnt++;
                if (w_done) w_done_cnt++;
            end
        end
    end

    // Measurement responder; latency 0 means done asserted in the trigger cycle with a poison value.
    initial begin
        meas_done = 1'b0;
        meas_data = '0;
        forever begin
            @(negedge clk);
            if (meas_start) begin
                if (meas_lat == 0) begin
                    meas_data = 32'hBAD0_BAD0;
                    meas_done = 1'b1;
                    @(negedge clk);
                    meas_data = {8'hD5, freq_out};
                    @(negedge clk);
                    meas_done = 1'b0;
                end else begin
                    repeat (meas_lat - 1) @(negedge clk);
                    meas_data = {8'hD5, freq_out};
                    meas_done = 1'b1;
                    @(negedge clk);
                    meas_done = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 3000);
        if (busy) flag({name, " timeout waiting for idle"});
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_meas_start(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!meas_start && k < 300);
        if (!meas_start) flag({name, " timeout waiting for meas_start"});
    endtask

    task automatic push_points(input int fs, input int fst, input int n);
        logic [FW-1:0] f;
        f = FW'(fs);
        for (int i = 0; i < n; i++) begin
            exp_freq.push_back(int'(f));
            exp_res.push_back('{idx: NW'(i), dat: {8'hD5, f}});
            f = f + FW'(fst);
        end
    endtask

    task automatic kick(input int fs, input int fst, input int n, input int s);
        f_start       = FW'(fs);
        f_step        = FW'(fst);
        n_points      = NW'(n);
        settle_cycles = SW'(s);
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    task automatic run_sweep(input int fs, input int fst, input int n, input int s,
                             input int lat, input bit mid_start);
        exp_gap  = s + 2;
        meas_lat = lat;
        push_points(fs, fst, n);
        exp_done.push_back(-1);
        @(negedge clk);
        kick(fs, fst, n, s);
        if (mid_start) begin
            repeat (4) @(negedge clk);
            f_start  = FW'(7);
            n_points = '0;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
        end
        wait_idle("sweep");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1; w_start = 1'b0;
        f_start = '0; f_step = '0; n_points = '0; settle_cycles = '0;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst freq_out", freq_out, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst res_valid", res_valid, 0);
        chk("rst strobes", {freq_load, meas_start}, 0);
        chk("rst res_index", res_index, 0);
        chk("rst res_data", res_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Wrap on the 8-bit instance: 250, 260 mod 256 = 4
        w_exp_freq.push_back(250);
        w_exp_freq.push_back(4);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int k = 0; k < 200 && w_busy; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("w idle", w_busy, 0);
        chk("w done pulses", w_done_cnt, 1);
        chk("w meas_start count", w_ms_cnt, 2);
        chk("w results", w_idx_exp, 2);
        chk("w freq left", w_exp_freq.size(), 0);

        // Basic three-point sweep
        run_sweep(1000, 250, 3, 2, 3, 1'b0);
        // Settle extremes; latency 0 also exercises the ignored trigger-cycle completion
        run_sweep(5000, 1, 1, 0, 0, 1'b0);
        run_sweep(20, 3, 2, 5, 2, 1'b0);

        // Backpressure: hold res_ready low for 10 OUTPUT cycles
        exp_gap = 3; meas_lat = 3;
        push_points(300, 40, 2);
        exp_done.push_back(-1);
        res_ready = 1'b0;
        kick(300, 40, 2, 1);
        begin
            int k = 0;
            while (!res_valid && k < 300) begin @(negedge clk); k++; end
            if (!res_valid) flag("hold timeout waiting for res_valid");
        end
        hold_chk = 1'b1;
        repeat (10) @(negedge clk);
        hold_chk  = 1'b0;
        res_ready = 1'b1;
        wait_idle("hold");

        // Abort during MEASURE, then a clean re-run from index 0
        exp_gap = 3; meas_lat = 6;
        exp_freq.push_back(9000);
        kick(9000, 100, 3, 1);
        wait_meas_start("abort");
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort res_valid", res_valid, 0);
        chk("abort done", done, 0);
        chk("abort freq kept", freq_out, 9000);
        repeat (10) @(negedge clk);
        chk("abort busy later", busy, 0);
        run_sweep(9000, 100, 3, 1, 2, 1'b0);

        // Empty sweep: done exactly one cycle after start, never busy
        @(negedge clk);
        exp_done.push_back(cyc + 1);
        kick(1, 1, 0, 0);
        chk("n0 busy", busy, 0);
        repeat (3) @(negedge clk);

        // Start while busy is ignored
        run_sweep(77, 11, 2, 1, 2, 1'b1);

        // Reset mid-sweep behaves as an abort with nothing retained
        exp_gap = 3; meas_lat = 4;
        exp_freq.push_back(4444);
        kick(4444, 1, 4, 1);
        wait_meas_start("reset");
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst freq_out", freq_out, 0);
        chk("mid rst res_valid", res_valid, 0);
        chk("mid rst done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post rst busy", busy, 0);

        chk("freq queue drained", exp_freq.size(), 0);
        chk("result queue drained", exp_res.size(), 0);
        chk("done queue drained", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ac_sweep_sequencer.md
AC_SWEEP_SEQUENCER -- requirements
Module: ac_sweep_sequencer

Interface
REQ-001 SHALL have parameter FW, default 24, meaning width of the frequency word driven to the AC source.
REQ-002 SHALL have parameter NW, default 10, meaning width of the sweep point count and index.
REQ-003 SHALL have parameter SW, default 16, meaning width of the settle-cycle count.
REQ-004 SHALL have parameter DW, default 32, meaning width of the measurement result.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port start  in  1  pulse that begins a sweep; honoured only in IDLE.
REQ-008 SHALL have port abort  in  1  terminates any sweep in progress.
REQ-009 SHALL have port f_start  in  FW  first frequency word.
REQ-010 SHALL have port f_step  in  FW  frequency increment per point.
REQ-011 SHALL have port n_points  in  NW  number of points in the sweep.
REQ-012 SHALL have port settle_cycles  in  SW  wait after each frequency load.
REQ-013 SHALL have port freq_out  out  FW  frequency word to the source.
REQ-014 SHALL have port freq_load  out  1  one-cycle strobe marking a new freq_out.
REQ-015 SHALL have port meas_start  out  1  one-cycle measurement trigger.
REQ-016 SHALL have port meas_done  in  1  measurement complete; qualifies meas_data.
REQ-017 SHALL have port meas_data  in  DW  measured value.
REQ-018 SHALL have port res_valid  out  1  result available.
REQ-019 SHALL have port res_ready  in  1  consumer accepts the result.
REQ-020 SHALL have port res_index  out  NW  point index of the result.
REQ-021 SHALL have port res_data  out  DW  captured measurement.
REQ-022 SHALL have port busy  out  1  high in every state except IDLE.
REQ-023 SHALL have port done  out  1  one-cycle pulse on normal sweep completion.

Function
REQ-024 SHALL implement states IDLE, LOAD, SETTLE, MEASURE, OUTPUT, DONE.
REQ-025 SHALL, in IDLE on start with n_points!=0, latch f_step, n_points and settle_cycles, set index=0 and freq_out=f_start, and enter LOAD.
REQ-026 SHALL, in IDLE on start with n_points==0, pulse done on the next cycle and remain IDLE.
REQ-027 SHALL assert freq_load for exactly the one LOAD cycle, load the settle counter with settle_cycles, and enter SETTLE.
REQ-028 SHALL decrement the counter in SETTLE and leave for MEASURE in the cycle the counter equals 0; SETTLE therefore lasts settle_cycles+1 cycles.
REQ-029 SHALL assert meas_start only in the first MEASURE cycle; meas_done SHALL be ignored in that cycle.
REQ-030 SHALL capture meas_data into res_data on meas_done and enter OUTPUT.
REQ-031 SHALL hold res_valid high in OUTPUT, with res_index and res_data stable, until res_ready is high.
REQ-032 SHALL, on the accepting handshake, go to DONE if index==n_points-1; otherwise increment index, set freq_out=freq_out+f_step modulo 2^FW (wraps silently), and go to LOAD.
REQ-033 SHALL pulse done for the single DONE cycle, then return to IDLE.
REQ-034 SHALL ignore start while busy.
REQ-035 SHALL, on abort in any non-IDLE state, enter IDLE on the next edge, with no done pulse and res_valid low from that edge; abort SHALL take priority over start, meas_done and handshake.
REQ-036 SHALL keep freq_out at its last value after DONE or abort.

Reset
REQ-037 SHALL, while rst_n is low, force state=IDLE, index=0, freq_out=0, res_data=0, and all strobes, res_valid, busy and done low.
REQ-038 SHALL treat reset during a sweep as abort without a done pulse; no output is retained.

Structure
REQ-039 SHALL place the state enumeration and default width constants in shared package ac_sweep_pkg.
REQ-040 SHALL use one sub-module, sweep_settle_timer (load/decrement/zero flag), for the settle counter.

Verification
REQ-041 SHALL check: f_start=1000, f_step=250, n_points=3, settle=2, res_ready=1 -> freq_load with 1000/1250/1500, res_index 0/1/2, one done pulse.
REQ-042 SHALL check: settle_cycles=0 -> meas_start exactly 2 cycles after freq_load; settle=5 -> 7 cycles.
REQ-043 SHALL check: res_ready low 10 cycles in OUTPUT -> res_valid, res_index and res_data stable; no new freq_load until acceptance.
REQ-044 SHALL check: FW=8, f_start=250, f_step=10, n_points=2 -> second freq_out = 4 (wrap).
REQ-045 SHALL check: abort during MEASURE -> IDLE next cycle, busy low, no done; a later start re-runs from index 0.
REQ-046 SHALL check: n_points=0 -> done one cycle later, no freq_load; start during a sweep has no effect.
